// File: rtl/spi_slave_engine_if.sv
// rtl/spi_slave_engine_if.sv - SPI pins, mode select and TX/RX word handshake bundle for spi_slave_engine
interface spi_slave_engine_if #(parameter int DATA_WIDTH = 8);
  logic                  i_sclk;
  logic                  i_cs_n;
  logic                  i_mosi;
  logic                  o_miso;
  logic                  o_miso_oe;
  logic                  i_cpol;
  logic                  i_cpha;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  o_busy;
  logic                  o_frame_err;
  logic                  o_tx_underrun;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_cpol, i_cpha, i_tx_data, i_tx_valid,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
    output o_busy, o_frame_err, o_tx_underrun
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_cpol, i_cpha, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
    input  o_busy, o_frame_err, o_tx_underrun
  );
endinterface

// File: rtl/spi_slave_engine.sv
// rtl/spi_slave_engine.sv - oversampled SPI slave with TX holding register; SPI_SLAVE_MODE_SEL_EN enables modes 0-3
module spi_slave_engine #(
  parameter int DATA_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_reset,
  spi_slave_engine_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic cpol, cpha, idle_sclk;

`ifdef SPI_SLAVE_MODE_SEL_EN
  logic cpol_q, cpha_q;
  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE) begin
      cpol_q <= bus.i_cpol;
      cpha_q <= bus.i_cpha;
    end
  end
  assign cpol      = cpol_q;
  assign cpha      = cpha_q;
  assign idle_sclk = bus.i_cpol;
`else
  logic unused_mode;
  assign unused_mode = bus.i_cpol ^ bus.i_cpha;
  assign cpol      = 1'b0;
  assign cpha      = 1'b0;
  assign idle_sclk = 1'b0;
`endif

  logic [1:0] sclk_s, cs_s, mosi_s, sync_vld;
  logic       sclk_prev, cs_prev, armed;

  // armed only after a genuine (post-reset) CS-high sample, so a reset mid-frame
  // needs a full CS high->low cycle before the next frame can start
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sclk_s    <= {2{idle_sclk}};
      cs_s      <= 2'b11;
      mosi_s    <= 2'b00;
      sync_vld  <= 2'b00;
      sclk_prev <= idle_sclk;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[0], bus.i_sclk};
      cs_s      <= {cs_s[0], bus.i_cs_n};
      mosi_s    <= {mosi_s[0], bus.i_mosi};
      sync_vld  <= {sync_vld[0], 1'b1};
      sclk_prev <= sclk_s[1];
      cs_prev   <= cs_s[1];
      if (sync_vld[1] && cs_s[1]) armed <= 1'b1;
    end
  end

  logic cs_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  assign cs_fall     = armed & cs_prev & ~cs_s[1];
  assign lead_edge   = (sclk_s[1] ^ cpol) & ~(sclk_prev ^ cpol);
  assign trail_edge  = ~(sclk_s[1] ^ cpol) & (sclk_prev ^ cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  logic [CW-1:0]         bit_cnt;
  logic                  active, do_sample, do_shift, word_done, load_tx, frame_abort;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    active      = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    word_done   = 1'b0;
    load_tx     = 1'b0;
    frame_abort = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = LOAD;
      end
      LOAD: begin
        active    = 1'b1;
        load_tx   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        active = 1'b1;
        if (cs_s[1]) begin
          state_nxt   = IDLE;
          frame_abort = (bit_cnt != '0);
        end else begin
          do_sample = sample_edge;
          // no shift before the first sample of a word: keeps the freshly loaded MSB
          do_shift  = shift_edge && (bit_cnt != '0);
          word_done = sample_edge && (bit_cnt == LAST);
          load_tx   = word_done;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] tx_sr, hold_data, rx_data;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic                  hold_full, rx_valid, frame_err, underrun, urun_pend;

  // A mid-frame reload from an empty holding register defers its underrun pulse
  // to the first sample of the word that actually carries the filler, so the
  // trailing reload after a frame's last word never reports.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bit_cnt   <= '0;
      tx_sr     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;
      urun_pend <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= frame_abort;
      if (state != SHIFT) begin
        bit_cnt   <= '0;
        urun_pend <= 1'b0;
      end
      if (do_sample) begin
        rx_sr   <= {rx_sr[DATA_WIDTH-3:0], mosi_s[1]};
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        if (bit_cnt == '0 && urun_pend) begin
          underrun  <= 1'b1;
          urun_pend <= 1'b0;
        end
        if (word_done) begin
          rx_data  <= {rx_sr, mosi_s[1]};
          rx_valid <= 1'b1;
        end
      end
      if (do_shift) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      if (bus.i_tx_valid && !hold_full) begin
        hold_data <= bus.i_tx_data;
        hold_full <= 1'b1;
      end
      if (load_tx) begin
        if (hold_full) begin
          tx_sr     <= hold_data;
          hold_full <= 1'b0;
        end else begin
          tx_sr <= '1;
          if (state == LOAD) underrun  <= 1'b1;
          else               urun_pend <= 1'b1;
        end
      end
    end
  end

  assign bus.o_miso        = active & tx_sr[DATA_WIDTH-1];
  assign bus.o_miso_oe     = active;
  assign bus.o_busy        = active;
  assign bus.o_tx_ready    = ~hold_full;
  assign bus.o_rx_data     = rx_data;
  assign bus.o_rx_valid    = rx_valid;
  assign bus.o_frame_err   = frame_err;
  assign bus.o_tx_underrun = underrun;
endmodule
